rv32i_reg_file: RTL and testbench



---
 rtl/riscv_32i_defs_pkg.sv | 14 +
 rtl/reg_file_intf.sv | 39 +++
 rtl/rv32i_reg_file.sv | 41 ++++
 tb/tb_rv32i_reg_file.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I definitions: architectural widths, register index type and the
// hard-wired zero register.
package riscv_32i_defs_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/reg_file_intf.sv
// Signal bundle for the integer register file; the monitor modport observes
// every signal passively.
interface reg_file_intf
  import riscv_32i_defs_pkg::*;
(
  input logic clk
);

  logic      wr_en;
  reg_addr_t wr_reg;
  word_t     wr_data;
  reg_addr_t rd_reg_1;
  reg_addr_t rd_reg_2;
  word_t     rd_data_1;
  word_t     rd_data_2;

  modport dut (
    input  clk,
    input  wr_en,
    input  wr_reg,
    input  wr_data,
    input  rd_reg_1,
    input  rd_reg_2,
    output rd_data_1,
    output rd_data_2
  );

  modport monitor (
    input clk,
    input wr_en,
    input wr_reg,
    input wr_data,
    input rd_reg_1,
    input rd_reg_2,
    input rd_data_1,
    input rd_data_2
  );

endinterface

// File: rtl/rv32i_reg_file.sv
// RV32I integer register file: x1..x31 storage, two combinational read ports,
// one synchronous write port; x0 has no storage and always reads zero.
module rv32i_reg_file #(
  parameter int unsigned XLEN     = riscv_32i_defs_pkg::XLEN,
  parameter int unsigned NUM_REGS = riscv_32i_defs_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = riscv_32i_defs_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_reg_1,
  input  logic [ADDR_W-1:0] rd_reg_2,
  output logic [XLEN-1:0]   rd_data_1,
  output logic [XLEN-1:0]   rd_data_2
);

  import riscv_32i_defs_pkg::*;

  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && (wr_reg != ZERO_REG)) begin
      regs_q[wr_reg] <= wr_data;
    end
  end

  // No write bypass: a same-cycle write becomes visible only after the edge.
  always_comb begin
    rd_data_1 = '0;
    rd_data_2 = '0;
    if (rd_reg_1 != ZERO_REG) rd_data_1 = regs_q[rd_reg_1];
    if (rd_reg_2 != ZERO_REG) rd_data_2 = regs_q[rd_reg_2];
  end

endmodule

// File: tb/tb_rv32i_reg_file.sv
// Self-checking bench for rv32i_reg_file: directed vector table, reset and
// read-during-write sequences, then randomized traffic against an array model.
module tb_rv32i_reg_file;

  logic clk;
  logic rst_n;

  reg_file_intf rf_if (.clk(clk));

  rv32i_reg_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (rf_if.wr_en),
    .wr_reg   (rf_if.wr_reg),
    .wr_data  (rf_if.wr_data),
    .rd_reg_1 (rf_if.rd_reg_1),
    .rd_reg_2 (rf_if.rd_reg_2),
    .rd_data_1(rf_if.rd_data_1),
    .rd_data_2(rf_if.rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] model [32];
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic [4:0] r1, input logic [4:0] r2);
    rf_if.wr_en    = we;
    rf_if.wr_reg   = wreg;
    rf_if.wr_data  = wdata;
    rf_if.rd_reg_1 = r1;
    rf_if.rd_reg_2 = r2;
  endtask

  // Clock one edge and mirror the architectural effect of the write in the model.
  task automatic clock_edge();
    @(posedge clk);
    if (rst_n && rf_if.wr_en && rf_if.wr_reg != 5'd0) model[rf_if.wr_reg] = rf_if.wr_data;
    #1;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_model();

    vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h00000000, 32'h12345678};
    vecs[2] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd0,  32'hA5A5A5A5, 32'h00000000};
    vecs[3] = '{1'b0, 5'd3,  32'h00000000, 5'd3,  5'd7,  32'hA5A5A5A5, 32'h12345678};
    vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd3,  32'hCAFEF00D, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hCAFEF00D};

    // Power-on reset with a write attempt that must be discarded.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h0BADF00D, 5'd5, 5'd0);
    @(posedge clk);
    #1;
    check("por_rd1", rf_if.rd_data_1, 32'h0);
    check("por_rd2", rf_if.rd_data_2, 32'h0);
    #2 rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].r1, vecs[i].r2);
      clock_edge();
      check($sformatf("vec%0d_rd1", i), rf_if.rd_data_1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rf_if.rd_data_2, vecs[i].e2);
    end

    // Read-during-write: old value before the edge, new value after.
    drive(1'b1, 5'd9, 32'h11111111, 5'd9, 5'd9);
    clock_edge();
    drive(1'b1, 5'd9, 32'h22222222, 5'd9, 5'd9);
    #6;
    check("rdw_before", rf_if.rd_data_1, 32'h11111111);
    clock_edge();
    check("rdw_after", rf_if.rd_data_1, 32'h22222222);

    // Mid-run asynchronous reset, asserted away from any clock edge.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd9);
    clock_edge();
    check("x5_written", rf_if.rd_data_1, 32'hDEADBEEF);
    drive(1'b1, 5'd5, 32'h5555AAAA, 5'd5, 5'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd1", rf_if.rd_data_1, 32'h0);
    check("async_rst_rd2", rf_if.rd_data_2, 32'h0);
    reset_model();
    clock_edge();
    check("rst_write_drop", rf_if.rd_data_1, 32'h0);
    #2 rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      rf_if.rd_reg_1 = 5'(i);
      rf_if.rd_reg_2 = 5'(31 - i);
      #1;
      check($sformatf("post_rst_x%0d", i), rf_if.rd_data_1, 32'h0);
      check($sformatf("post_rst_x%0d_p2", 31 - i), rf_if.rd_data_2, 32'h0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic; reads checked before each edge, so no bypass is allowed.
    for (int n = 0; n < 1000; n++) begin
      logic [4:0]  wreg;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        we;
      wreg = 5'($urandom_range(0, 31));
      we   = ($urandom_range(0, 3) != 0);
      r1   = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
      r2   = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      drive(we, wreg, 32'($urandom), r1, r2);
      #1;
      check($sformatf("rnd%0d_rd1", n), rf_if.rd_data_1, model[r1]);
      check($sformatf("rnd%0d_rd2", n), rf_if.rd_data_2, model[r2]);
      clock_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
